// File: rtl/logicunit_driver.sv
// logicunit_driver: self-test stimulus and checking engine for a 2-bit-control
// logic unit. On start it walks every (a, b, control) combination onto the unit,
// compares the returned result with an internal reference and reports the
// mismatch count, the first failing vector index and done/pass status.
// Optional build macro: LOGICUNIT_DRIVER_STOP_ON_FAIL_EN ends a run at the first
// mismatch instead of applying all vectors.
module logicunit_driver #(
    parameter int WIDTH = 1,
    parameter int ERR_W = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     dut_out,
    output logic [WIDTH-1:0]     a,
    output logic [WIDTH-1:0]     b,
    output logic [1:0]           control,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_W-1:0]     err_count,
    output logic [2*WIDTH+1:0]   fail_index
);

    localparam int IDX_W = 2*WIDTH + 2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [IDX_W-1:0] r_idx;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [1:0]       r_ctrl;
    logic [WIDTH-1:0] r_exp;
    logic [ERR_W-1:0] r_err;
    logic [IDX_W-1:0] r_fail;

    logic             w_launch;
    logic             w_mismatch;
    logic             w_last;
    logic             w_stop;
    logic             w_err_sat;
    logic [IDX_W-1:0] w_next_idx;

    // Reference result for a vector index, decoded with the same field mapping
    // that drives a, b and control.
    function automatic logic [WIDTH-1:0] f_ref(input logic [IDX_W-1:0] idx);
        logic [WIDTH-1:0] fa;
        logic [WIDTH-1:0] fb;
        logic [1:0]       fc;
        fa = idx[WIDTH-1:0];
        fb = idx[2*WIDTH-1:WIDTH];
        fc = idx[IDX_W-1:2*WIDTH];
        case (fc)
            2'd0:    return fa & fb;
            2'd1:    return fa | fb;
            2'd2:    return ~(fa | fb);
            default: return fa ^ fb;
        endcase
    endfunction

    // A run may only be launched from IDLE or DONE; start is ignored in RUN.
    assign w_launch   = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_mismatch = (dut_out != r_exp);
    assign w_last     = (r_idx == {IDX_W{1'b1}});
    assign w_next_idx = r_idx + {{(IDX_W-1){1'b0}}, 1'b1};
    assign w_err_sat  = &r_err;

`ifdef LOGICUNIT_DRIVER_STOP_ON_FAIL_EN
    // First mismatch terminates the run at the same edge it is detected.
    assign w_stop = w_last || w_mismatch;
`else
    // Every vector is always applied.
    assign w_stop = w_last;
`endif

    // Sequencer: state, current index, and the vector/expected pair driven to the unit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_ctrl  <= '0;
            r_exp   <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_launch) begin
                        r_state <= S_RUN;
                        r_idx   <= '0;
                        r_a     <= '0;
                        r_b     <= '0;
                        r_ctrl  <= '0;
                        r_exp   <= f_ref('0);
                    end
                end
                S_RUN: begin
                    if (w_stop) begin
                        // Park the operand bus at zero once checking is over.
                        r_state <= S_DONE;
                        r_a     <= '0;
                        r_b     <= '0;
                        r_ctrl  <= '0;
                        r_exp   <= '0;
                    end else begin
                        r_idx   <= w_next_idx;
                        r_a     <= w_next_idx[WIDTH-1:0];
                        r_b     <= w_next_idx[2*WIDTH-1:WIDTH];
                        r_ctrl  <= w_next_idx[IDX_W-1:2*WIDTH];
                        r_exp   <= f_ref(w_next_idx);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Error accounting: saturating mismatch count and index of the first failure.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err  <= '0;
            r_fail <= '0;
        end else if (w_launch) begin
            r_err  <= '0;
            r_fail <= '0;
        end else if ((r_state == S_RUN) && w_mismatch) begin
            if (!w_err_sat) begin
                r_err <= r_err + {{(ERR_W-1){1'b0}}, 1'b1};
            end
            if (r_err == '0) begin
                r_fail <= r_idx;
            end
        end
    end

    assign a          = r_a;
    assign b          = r_b;
    assign control    = r_ctrl;
    assign busy       = (r_state == S_RUN);
    assign done       = (r_state == S_DONE);
    assign pass       = done && (r_err == '0);
    assign err_count  = r_err;
    assign fail_index = r_fail;

endmodule

// File: tb/tb_logicunit_driver.sv
// Scoreboard bench for logicunit_driver. Each instance drives a table-based
// emulated logic unit; expected results are derived from the operation table
// and pushed to queues, and monitor processes pop and compare.
module tb_logicunit_driver;

    typedef struct {
        int err;
        int fail;
        int pass;
        int cyc;
    } exp_t;

    logic clk;
    logic reset_n;

    // Instance 1: WIDTH=1, default count width.
    logic       start1;
    logic [0:0] dut_out1;
    logic [0:0] a1, b1;
    logic [1:0] control1;
    logic       busy1, done1, pass1;
    logic [15:0] err1;
    logic [3:0]  fail1;

    // Instance 2: WIDTH=2, 2-bit count to exercise saturation.
    logic       start2;
    logic [1:0] dut_out2;
    logic [1:0] a2, b2;
    logic [1:0] control2;
    logic       busy2, done2, pass2;
    logic [1:0] err2;
    logic [5:0] fail2;

    logic [0:0] resp1 [16];
    logic [1:0] resp2 [64];

    int   vq1[$];
    exp_t rq1[$];
    exp_t rq2[$];

    int total = 0;
    int bad   = 0;

    assign dut_out1 = resp1[{control1, b1, a1}];
    assign dut_out2 = resp2[{control2, b2, a2}];

    logicunit_driver #(.WIDTH(1), .ERR_W(16)) u1 (
        .clk(clk), .reset_n(reset_n), .start(start1), .dut_out(dut_out1),
        .a(a1), .b(b1), .control(control1), .busy(busy1), .done(done1),
        .pass(pass1), .err_count(err1), .fail_index(fail1)
    );

    logicunit_driver #(.WIDTH(2), .ERR_W(2)) u2 (
        .clk(clk), .reset_n(reset_n), .start(start2), .dut_out(dut_out2),
        .a(a2), .b(b2), .control(control2), .busy(busy2), .done(done2),
        .pass(pass2), .err_count(err2), .fail_index(fail2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int act, input int expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Operation table applied to a vector index of operand width w.
    function automatic int ref_val(input int w, input int idx);
        int m, av, bv, c;
        m  = (1 << w) - 1;
        av = idx & m;
        bv = (idx >> w) & m;
        c  = (idx >> (2*w)) & 3;
        case (c)
            0:       return av & bv;
            1:       return av | bv;
            2:       return (~(av | bv)) & m;
            default: return av ^ bv;
        endcase
    endfunction

    // Expected outcome of one run of instance 1 with the current resp1 table.
    task automatic build_exp1();
        exp_t e;
        int last;
        e.err = 0; e.fail = 0; last = 15;
        for (int i = 0; i < 16; i++) begin
            if (int'(resp1[i]) != ref_val(1, i)) begin
                if (e.err == 0) e.fail = i;
                e.err++;
`ifdef LOGICUNIT_DRIVER_STOP_ON_FAIL_EN
                last = i;
                break;
`endif
            end
        end
        for (int i = 0; i <= last; i++) vq1.push_back(i);
        e.cyc  = last + 1;
        e.pass = (e.err == 0) ? 1 : 0;
        rq1.push_back(e);
    endtask

    // Expected outcome for instance 2; its count saturates at 3.
    task automatic build_exp2();
        exp_t e;
        int last;
        e.err = 0; e.fail = 0; last = 63;
        for (int i = 0; i < 64; i++) begin
            if (int'(resp2[i]) != ref_val(2, i)) begin
                if (e.err == 0) e.fail = i;
                e.err++;
`ifdef LOGICUNIT_DRIVER_STOP_ON_FAIL_EN
                last = i;
                break;
`endif
            end
        end
        if (e.err > 3) e.err = 3;
        e.cyc  = last + 1;
        e.pass = (e.err == 0) ? 1 : 0;
        rq2.push_back(e);
    endtask

    task automatic pulse_start(input int which);
        @(posedge clk);
        #1;
        if (which == 1) start1 = 1'b1; else start2 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic wait_runs();
        for (int k = 0; k < 300 && (rq1.size() != 0 || rq2.size() != 0); k++) @(negedge clk);
        #1;
        chk("run_timeout", rq1.size() + rq2.size(), 0);
        vq1.delete();
        rq1.delete();
        rq2.delete();
    endtask

    task automatic fill_correct1();
        for (int i = 0; i < 16; i++) resp1[i] = 1'(ref_val(1, i));
    endtask

    // Monitor for instance 1: vector order, idle bus, and end-of-run results.
    initial begin
        int cyc;
        logic prev_done;
        exp_t e;
        cyc = 0;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                cyc = 0;
                prev_done = 1'b0;
            end else begin
                if (busy1 || done1) chk("u1_busy_done_excl", int'(busy1 && done1), 0);
                if (busy1) begin
                    cyc++;
                    if (vq1.size() == 0) begin
                        chk("u1_extra_vector", int'({control1, b1, a1}), -1);
                    end else begin
                        chk("u1_vector", int'({control1, b1, a1}), vq1.pop_front());
                    end
                end else begin
                    chk("u1_bus_idle", int'({control1, b1, a1}), 0);
                end
                if (done1 && !prev_done) begin
                    if (rq1.size() == 0) begin
                        chk("u1_unexpected_done", 1, 0);
                    end else begin
                        e = rq1.pop_front();
                        chk("u1_err_count", int'(err1), e.err);
                        if (e.err != 0) chk("u1_fail_index", int'(fail1), e.fail);
                        chk("u1_pass", int'(pass1), e.pass);
                        chk("u1_cycles", cyc, e.cyc);
                        $display("run u1: err=%0d fail=%0d pass=%0d cycles=%0d", err1, fail1, pass1, cyc);
                    end
                    cyc = 0;
                end
                prev_done = done1;
            end
        end
    end

    // Monitor for instance 2: end-of-run results and cycle count.
    initial begin
        int cyc;
        logic prev_done;
        exp_t e;
        cyc = 0;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                cyc = 0;
                prev_done = 1'b0;
            end else begin
                if (busy2 || done2) chk("u2_busy_done_excl", int'(busy2 && done2), 0);
                if (busy2) cyc++;
                if (done2 && !prev_done) begin
                    if (rq2.size() == 0) begin
                        chk("u2_unexpected_done", 1, 0);
                    end else begin
                        e = rq2.pop_front();
                        chk("u2_err_count", int'(err2), e.err);
                        if (e.err != 0) chk("u2_fail_index", int'(fail2), e.fail);
                        chk("u2_pass", int'(pass2), e.pass);
                        chk("u2_cycles", cyc, e.cyc);
                        $display("run u2: err=%0d fail=%0d pass=%0d cycles=%0d", err2, fail2, pass2, cyc);
                    end
                    cyc = 0;
                end
                prev_done = done2;
            end
        end
    end

    initial begin
        int v;
        reset_n = 1'b0;
        start1  = 1'b0;
        start2  = 1'b0;
        fill_correct1();
        for (int i = 0; i < 64; i++) resp2[i] = 2'(ref_val(2, i));
        repeat (3) @(posedge clk);
        #1;
        // Reset state of both instances.
        chk("rst_u1_bus",  int'({control1, b1, a1}), 0);
        chk("rst_u1_flags", int'({busy1, done1, pass1}), 0);
        chk("rst_u1_err",  int'(err1), 0);
        chk("rst_u1_fail", int'(fail1), 0);
        chk("rst_u2_flags", int'({busy2, done2, pass2}), 0);
        chk("rst_u2_err",  int'(err2), 0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Correct unit: full clean run.
        fill_correct1();
        build_exp1();
        pulse_start(1);
        wait_runs();

        // Stuck-at-0 unit.
        for (int i = 0; i < 16; i++) resp1[i] = 1'b0;
        build_exp1();
        pulse_start(1);
        wait_runs();

        // Randomly faulted units, restarted from DONE each time.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 16; i++)
                resp1[i] = 1'(ref_val(1, i)) ^ 1'($urandom_range(0, 3) == 0);
            build_exp1();
            pulse_start(1);
            wait_runs();
        end

        // Restart from DONE after an error run: counters must clear at launch.
        for (int i = 0; i < 16; i++) resp1[i] = 1'b0;
        build_exp1();
        pulse_start(1);
        wait_runs();
        fill_correct1();
        build_exp1();
        pulse_start(1);
        chk("restart_err_clear", int'(err1), 0);
        chk("restart_busy", int'(busy1), 1);
        wait_runs();

        // start pulsed again mid-run is ignored.
        fill_correct1();
        build_exp1();
        pulse_start(1);
        repeat (5) @(posedge clk);
        pulse_start(1);
        wait_runs();

        // Asynchronous reset while vector 8 is driven.
        fill_correct1();
        build_exp1();
        pulse_start(1);
        v = -1;
        for (int k = 0; k < 40; k++) begin
            v = int'({control1, b1, a1});
            if (busy1 && v == 8) break;
            @(posedge clk);
            #1;
        end
        chk("reach_vector8", v, 8);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_bus", int'({control1, b1, a1}), 0);
        chk("async_rst_flags", int'({busy1, done1, pass1}), 0);
        chk("async_rst_err", int'(err1), 0);
        chk("async_rst_fail", int'(fail1), 0);
        vq1.delete();
        rq1.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        build_exp1();
        pulse_start(1);
        wait_runs();

        // Inverting WIDTH=2 unit with saturating 2-bit count.
        for (int i = 0; i < 64; i++) resp2[i] = 2'(~ref_val(2, i));
        build_exp2();
        pulse_start(2);
        wait_runs();

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/logicunit_driver.md
# logicunit_driver

Self-checking stimulus engine for the 2-bit-control logic unit. On `start` it walks every combination of `a`, `b` and `control` onto the unit's inputs, one vector per clock. It compares the unit's combinational output against an internal reference model and reports the error count, the first failing vector and pass/done status. It is the driving and checking end of the logic-unit interface, used for on-chip and FPGA self-test in place of a simulation-only bench.

## Interface
- `WIDTH`, default 1: operand width of `a`, `b` and `dut_out`. Legal range 1..4.
- `ERR_W`, default 16: width of `err_count`.
- `clk` input 1: single clock; all state changes on its rising edge.
- `reset_n` input 1: reset, asynchronous and active-low.
- `start` input 1: begin a run; sampled in IDLE or DONE, ignored in RUN.
- `dut_out` input WIDTH: combinational result returned by the logic unit under test.
- `a` output WIDTH: operand A driven to the unit (registered).
- `b` output WIDTH: operand B driven to the unit (registered).
- `control` output 2: operation select driven to the unit (registered).
- `busy` output 1: high in RUN.
- `done` output 1: high in DONE; stays high until restart or reset.
- `pass` output 1: equals `done && err_count == 0`.
- `err_count` output ERR_W: number of mismatching vectors; saturates at all-ones.
- `fail_index` output 2*WIDTH+2: vector index of the first mismatch; meaningful only when `err_count != 0`.

## Operation
- Vector index `i` runs 0..N-1, with N = 2^(2*WIDTH+2). Field mapping:
  - `a = i[WIDTH-1:0]`
  - `b = i[2*WIDTH-1:WIDTH]`
  - `control = i[2*WIDTH+1:2*WIDTH]`, so control varies slowest.
- Reference model, bitwise over WIDTH:
  - control 0: `a & b`
  - control 1: `a | b`
  - control 2: `~(a | b)`
  - control 3: `a ^ b`
- Expected value is registered alongside `a`, `b` and `control`, so it always corresponds to the vector currently driven.
- States:
  - IDLE: outputs `a`, `b`, `control` are 0; `busy` = 0; `done` = 0.
  - IDLE --`start`--> RUN: clear `err_count` and `fail_index`; load vector 0.
  - RUN: on each edge, compare `dut_out` against expected for the vector currently driven, then load the next vector.
  - RUN --(last vector compared)--> DONE: `a`, `b`, `control` return to 0.
  - DONE --`start`--> RUN: same clearing as from IDLE.
- Mismatch on an edge:
  - `err_count` increments, saturating at all-ones.
  - If `err_count` was 0 before the increment, `fail_index` captures the index of the vector being compared.
- Reset: asynchronous at any time, including mid-run. Every register clears and the state returns to IDLE.
  - Reset values: `a`, `b`, `control`, `busy`, `done`, `pass`, `err_count`, `fail_index` all 0.
- `start` held high continuously: a new run starts on the first edge in IDLE or DONE. Runs are not queued.

## Timing
- Edge E0 samples `start` = 1 in IDLE or DONE. Vector 0 is driven during the cycle that follows.
- Vector k is driven during the cycle after edge E(k).
- `dut_out` for vector k is sampled at edge E(k+1). The unit has the full cycle as its combinational budget.
- Edge E(N) compares vector N-1 and enters DONE.
  - `done`/`pass` rise in the cycle after E(N), i.e. N cycles after the start edge.
  - WIDTH = 1: 16 cycles.
- `busy` is high from the cycle after E0 through the cycle before `done` rises. `busy` and `done` are never high together.
- `err_count` and `fail_index` update at the same edge as the comparison. They are final when `done` = 1.

## Configuration
- `LOGICUNIT_DRIVER_STOP_ON_FAIL_EN` defined:
  - The first mismatch moves RUN to DONE at that same edge.
  - `err_count` = 1; `fail_index` holds the failing vector.
  - Remaining vectors are not applied.
- Macro undefined: all N vectors always run, and `err_count` is the total mismatch count.

## Test plan
- Correct model DUT, WIDTH = 1, pulse `start` -> `busy` for 16 cycles, then `done` = 1, `pass` = 1, `err_count` = 0; `a`/`b`/`control` step through indices 0..15 in order.
- Stuck-at-0 DUT, WIDTH = 1, macro undefined -> `err_count` = 7 (AND 1 + OR 3 + NOR 1 + XOR 2), `fail_index` = 3, `pass` = 0, `done` after 16 cycles.
- Stuck-at-0 DUT with `LOGICUNIT_DRIVER_STOP_ON_FAIL_EN` -> `done` rises in the cycle after E4; `err_count` = 1; `fail_index` = 3.
- Inverting DUT (`~model`), WIDTH = 2 -> 64 cycles; `err_count` = 64; `fail_index` = 0.
- Assert `reset_n` = 0 while vector 8 is driven -> all outputs 0 immediately, without waiting for a clock edge; after release, `start` gives a full clean 16-vector run with `pass` = 1.
- `start` re-pulsed during RUN -> ignored, run completes at cycle 16. `start` pulsed in DONE -> counters clear and a new run begins.
